// File: rtl/uart_rx_frame_buffer.sv
// Banked UART receive frame buffer: symbols fill NUM_BANKS banks round-robin,
// completed frames are read and released by the host over the register bus.
module uart_rx_frame_buffer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned AUTO_CLOSE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_vld,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              frame_done,
  input  logic [31:0]       bus_addr_in,
  input  logic [31:0]       bus_data_in,
  input  logic              bus_read_en,
  input  logic              bus_write_en,
  input  logic [31:0]       bus_base_addr,
  output logic [31:0]       bus_data_out,
  output logic              bus_data_out_en,
  output logic              irq
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned ADDR_W = BANK_W + PTR_W;
  localparam int unsigned MEM_N  = NUM_BANKS * DEPTH;

  typedef enum logic [1:0] {FREE = 2'd0, FILLING = 2'd1, READY = 2'd2} bank_st_t;

  bank_st_t          st_q   [NUM_BANKS];
  bank_st_t          st_n   [NUM_BANKS];
  logic [CNT_W-1:0]  len_q  [NUM_BANKS];
  logic [CNT_W-1:0]  len_n  [NUM_BANKS];
  logic [BANK_W-1:0] wbank_q, wbank_n, rbank_q, rbank_n, wnext, rnext;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_n, len_inc;
  logic              overflow_q, overflow_n, stall_q, stall_n;
  logic [15:0]       drop_q, drop_n;
  logic [31:0]       rdata_q, rdata_n, off, status;
  logic              sel_mem_q, sel_mem_n, rsp_n;
  logic [7:0]        rdy_cnt;
  logic              frame_avail, wr_ok, auto_full, close, pop_ok, rd_hit, wr_ctrl;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] mem_q;
  logic              unused;

  assign unused = ^bus_data_in[31:3];

  // Bus decode and bank bookkeeping shared by the next-state logic
  always_comb begin
    off         = bus_addr_in - bus_base_addr;
    rd_hit      = bus_read_en && (off == 32'h0 || off == 32'h4 || off == 32'h8);
    wr_ctrl     = bus_write_en && !bus_read_en && (off == 32'hC);
    wnext       = (wbank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : wbank_q + BANK_W'(1);
    rnext       = (rbank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : rbank_q + BANK_W'(1);
    frame_avail = (st_q[rbank_q] == READY);
    wr_ok       = rx_vld && !stall_q && (st_q[wbank_q] == FILLING) &&
                  (len_q[wbank_q] < CNT_W'(DEPTH));
    len_inc     = len_q[wbank_q] + CNT_W'(wr_ok);
    auto_full   = (AUTO_CLOSE != 0) && (len_inc == CNT_W'(DEPTH));
    close       = (frame_done || auto_full) && !stall_q &&
                  (st_q[wbank_q] == FILLING) && (len_inc != '0);
    pop_ok      = frame_avail && (rd_ptr_q != len_q[rbank_q]);
    rdy_cnt     = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (st_q[b] == READY) rdy_cnt = rdy_cnt + 8'd1;
    status      = {drop_q, rdy_cnt, 5'd0, stall_q, overflow_q, frame_avail};
  end

  // Next-state: write path, bank close/stall, register reads, control writes
  always_comb begin
    st_n       = st_q;
    len_n      = len_q;
    wbank_n    = wbank_q;
    rbank_n    = rbank_q;
    rd_ptr_n   = rd_ptr_q;
    overflow_n = overflow_q;
    stall_n    = stall_q;
    drop_n     = drop_q;
    rdata_n    = rdata_q;
    sel_mem_n  = sel_mem_q;
    rsp_n      = 1'b0;
    mem_we     = wr_ok;
    mem_re     = 1'b0;
    mem_waddr  = {wbank_q, len_q[wbank_q][PTR_W-1:0]};
    mem_raddr  = {rbank_q, rd_ptr_q[PTR_W-1:0]};

    if (wr_ok) len_n[wbank_q] = len_inc;
    if (rx_vld && !wr_ok) begin
      overflow_n = 1'b1;
      if (drop_q != 16'hFFFF) drop_n = drop_q + 16'd1;
    end

    // Next bank is judged on registered state, so a same-cycle release still stalls
    if (close) begin
      st_n[wbank_q] = READY;
      if (st_q[wnext] == FREE) begin
        st_n[wnext]  = FILLING;
        len_n[wnext] = '0;
        wbank_n      = wnext;
      end else begin
        stall_n = 1'b1;
      end
    end else if (stall_q && st_q[wnext] == FREE) begin
      st_n[wnext]  = FILLING;
      len_n[wnext] = '0;
      wbank_n      = wnext;
      stall_n      = 1'b0;
    end

    if (rd_hit) begin
      rsp_n     = 1'b1;
      sel_mem_n = 1'b0;
      case (off)
        32'h0:   rdata_n = status;
        32'h4:   rdata_n = frame_avail ? 32'(len_q[rbank_q]) : 32'd0;
        default: begin
          rdata_n = 32'd0;
          if (pop_ok) begin
            mem_re    = 1'b1;
            sel_mem_n = 1'b1;
            rd_ptr_n  = rd_ptr_q + CNT_W'(1);
          end
        end
      endcase
    end

    if (wr_ctrl) begin
      if (bus_data_in[1]) begin
        overflow_n = 1'b0;
        drop_n     = '0;
      end
      if (bus_data_in[2]) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          st_n[b]  = (b == 0) ? FILLING : FREE;
          len_n[b] = '0;
        end
        wbank_n  = '0;
        rbank_n  = '0;
        rd_ptr_n = '0;
        stall_n  = 1'b0;
      end else if (bus_data_in[0] && frame_avail) begin
        st_n[rbank_q]  = FREE;
        len_n[rbank_q] = '0;
        rd_ptr_n       = '0;
        rbank_n        = rnext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= (b == 0) ? FILLING : FREE;
        len_q[b] <= '0;
      end
      wbank_q         <= '0;
      rbank_q         <= '0;
      rd_ptr_q        <= '0;
      overflow_q      <= 1'b0;
      stall_q         <= 1'b0;
      drop_q          <= '0;
      rdata_q         <= '0;
      sel_mem_q       <= 1'b0;
      bus_data_out_en <= 1'b0;
      irq             <= 1'b0;
    end else begin
      st_q            <= st_n;
      len_q           <= len_n;
      wbank_q         <= wbank_n;
      rbank_q         <= rbank_n;
      rd_ptr_q        <= rd_ptr_n;
      overflow_q      <= overflow_n;
      stall_q         <= stall_n;
      drop_q          <= drop_n;
      rdata_q         <= rdata_n;
      sel_mem_q       <= sel_mem_n;
      bus_data_out_en <= rsp_n;
      irq             <= frame_avail;
    end
  end

  // Frame storage, synchronous read; mem_q only moves on a successful pop
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= rx_data;
    if (mem_re) mem_q <= mem[mem_raddr];
  end

  assign bus_data_out = sel_mem_q ? 32'(mem_q) : rdata_q;

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// Scoreboard bench: two instances (AUTO_CLOSE 0/1, DEPTH 16), directed vectors,
// expected bus responses and output probes queued by stimulus, checked by a monitor.
module tb_uart_rx_frame_buffer;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned NB  = 2;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [33:0] ALL  = 34'h3_FFFF_FFFF;

  typedef struct {
    logic [31:0] d;
    int          cyc;
    string       name;
  } rsp_t;

  typedef struct {
    int          t;
    int          cyc;
    logic [33:0] mask;
    logic [33:0] exp;
    string       name;
  } probe_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rx_vld, frame_done, rd_en, wr_en;
  logic [DW-1:0] rx_data;
  logic [31:0]   addr, wdata;
  logic [31:0]   dout0, dout1;
  logic [1:0]    den, irqv;

  rsp_t   rq0[$];
  rsp_t   rq1[$];
  probe_t pq[$];
  int     cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  bit     done   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_buffer #(.DATA_W(DW), .DEPTH(DEP), .NUM_BANKS(NB), .AUTO_CLOSE(0)) dut0 (
    .clk(clk), .rst(rst), .rx_vld(rx_vld[0]), .rx_data(rx_data), .frame_done(frame_done[0]),
    .bus_addr_in(addr), .bus_data_in(wdata), .bus_read_en(rd_en[0]), .bus_write_en(wr_en[0]),
    .bus_base_addr(BASE), .bus_data_out(dout0), .bus_data_out_en(den[0]), .irq(irqv[0]));

  uart_rx_frame_buffer #(.DATA_W(DW), .DEPTH(DEP), .NUM_BANKS(NB), .AUTO_CLOSE(1)) dut1 (
    .clk(clk), .rst(rst), .rx_vld(rx_vld[1]), .rx_data(rx_data), .frame_done(frame_done[1]),
    .bus_addr_in(addr), .bus_data_in(wdata), .bus_read_en(rd_en[1]), .bus_write_en(wr_en[1]),
    .bus_base_addr(BASE), .bus_data_out(dout1), .bus_data_out_en(den[1]), .irq(irqv[1]));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic probe(input int t, input logic [33:0] mask, input logic [33:0] exp,
                       input string nm);
    probe_t p;
    p.t = t; p.cyc = cyc + 1; p.mask = mask; p.exp = exp; p.name = nm;
    pq.push_back(p);
  endtask

  task automatic send(input int t, input logic [7:0] d, input bit with_done = 1'b0);
    rx_vld[t] = 1'b1; rx_data = d; frame_done[t] = with_done;
    tick();
    rx_vld[t] = 1'b0; frame_done[t] = 1'b0;
  endtask

  task automatic close(input int t);
    frame_done[t] = 1'b1;
    tick();
    frame_done[t] = 1'b0;
  endtask

  task automatic rd(input int t, input logic [31:0] off, input logic [31:0] exp,
                    input string nm);
    rsp_t e;
    e.d = exp; e.cyc = cyc + 1; e.name = nm;
    if (t == 0) rq0.push_back(e); else rq1.push_back(e);
    addr = BASE + off; rd_en[t] = 1'b1;
    tick();
    rd_en[t] = 1'b0;
  endtask

  task automatic rd_none(input int t, input logic [31:0] off, input string nm);
    probe(t, 34'h1_0000_0000, 34'h0, nm);
    addr = BASE + off; rd_en[t] = 1'b1;
    tick();
    rd_en[t] = 1'b0;
  endtask

  task automatic wr(input int t, input logic [31:0] off, input logic [31:0] d,
                    input bit with_rd = 1'b0);
    if (with_rd) probe(t, 34'h1_0000_0000, 34'h0, "rdwr_no_rsp");
    addr = BASE + off; wdata = d; wr_en[t] = 1'b1; rd_en[t] = with_rd;
    tick();
    wr_en[t] = 1'b0; rd_en[t] = 1'b0;
  endtask

  // Monitor: pops expected responses and probes, keeps the counts, ends the run
  always @(negedge clk) begin
    logic [31:0] d;
    logic [33:0] act;
    rsp_t        r;
    probe_t      p;
    for (int t = 0; t < 2; t++) begin
      d = (t == 0) ? dout0 : dout1;
      if (den[t]) begin
        checks++;
        if ((t == 0 ? rq0.size() : rq1.size()) == 0) begin
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got 0x%08h, expected no response", t, d);
        end else begin
          r = (t == 0) ? rq0.pop_front() : rq1.pop_front();
          if (r.d !== d || r.cyc != cyc) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%08h at cycle %0d, expected 0x%08h at cycle %0d",
                     r.name, t, d, cyc, r.d, r.cyc);
          end
        end
      end else if ((t == 0 ? rq0.size() : rq1.size()) > 0) begin
        r = (t == 0) ? rq0[0] : rq1[0];
        if (r.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s dut%0d: no response, expected 0x%08h at cycle %0d",
                   r.name, t, r.d, r.cyc);
          if (t == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
        end
      end
    end
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p   = pq.pop_front();
      act = (p.t == 0) ? {irqv[0], den[0], dout0} : {irqv[1], den[1], dout1};
      checks++;
      if ((act & p.mask) !== (p.exp & p.mask)) begin
        errors++;
        $display("FAIL %s dut%0d: got {irq,en,data}=0x%09h, expected 0x%09h (mask 0x%09h)",
                 p.name, p.t, act, p.exp, p.mask);
      end
    end
    if (done || cyc > 5000) begin
      checks++;
      if (!done || rq0.size() != 0 || rq1.size() != 0 || pq.size() != 0) begin
        errors++;
        $display("FAIL end_of_run: done=%0d pending rsp %0d/%0d probes %0d, expected done=1 and none",
                 done, rq0.size(), rq1.size(), pq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; rx_vld = '0; frame_done = '0; rd_en = '0; wr_en = '0;
    rx_data = '0; addr = '0; wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    probe(0, ALL, 34'h0, "reset_outputs");
    tick();
    rd(0, 32'h0, 32'h0, "reset_status");
    rd(0, 32'h4, 32'h0, "reset_len");

    // Single 5-symbol frame, drained then released
    for (int i = 0; i < 5; i++) send(0, 8'h11 + 8'(i));
    close(0);
    tick();
    rd(0, 32'h0, 32'h0000_0101, "t1_status");
    probe(0, 34'h2_0000_0000, 34'h2_0000_0000, "t1_irq");
    rd(0, 32'h4, 32'd5, "t1_len");
    for (int i = 0; i < 5; i++) rd(0, 32'h8, 32'h11 + 32'(i), "t1_pop");
    rd(0, 32'h8, 32'h0, "t1_pop_empty");
    wr(0, 32'hC, 32'h1);
    rd(0, 32'h0, 32'h0, "t1_released_status");
    probe(0, 34'h2_0000_0000, 34'h0, "t1_irq_low");
    tick();

    // Both banks full -> stall and drops; release resolves the stall
    wr(0, 32'hC, 32'h4);
    rd(0, 32'h0, 32'h0, "flush_status");
    for (int i = 0; i < 3; i++) send(0, 8'hA1 + 8'(i));
    close(0);
    for (int i = 0; i < 3; i++) send(0, 8'hB1 + 8'(i));
    close(0);
    for (int i = 0; i < 4; i++) send(0, 8'hC1 + 8'(i));
    close(0);
    rd(0, 32'h0, 32'h0004_0207, "t2_stall_status");
    rd(0, 32'h4, 32'd3, "t2_len");
    rd(0, 32'h8, 32'hA1, "t2_pop_bank0");
    wr(0, 32'hC, 32'h1);
    tick();
    rd(0, 32'h0, 32'h0004_0103, "t2_after_release");
    rd(0, 32'h4, 32'd3, "t2_len_bank1");
    rd(0, 32'h8, 32'hB1, "t2_pop_bank1");
    wr(0, 32'hC, 32'h2);
    rd(0, 32'h0, 32'h0000_0101, "t2_clear_status");
    wr(0, 32'hC, 32'h4);

    // Overfill a bank without auto-close
    for (int i = 0; i < 20; i++) send(0, 8'h20 + 8'(i));
    close(0);
    rd(0, 32'h0, 32'h0004_0103, "t3_status");
    rd(0, 32'h4, 32'd16, "t3_len");
    rd(0, 32'h8, 32'h20, "t3_pop");
    wr(0, 32'hC, 32'h6);
    rd(0, 32'h0, 32'h0, "t3_clear_flush");

    // Auto-close instance spills into the second bank
    for (int i = 0; i < 20; i++) send(1, 8'h40 + 8'(i));
    close(1);
    rd(1, 32'h0, 32'h0000_0205, "ac_status");
    rd(1, 32'h4, 32'd16, "ac_len_bank0");
    rd(1, 32'h8, 32'h40, "ac_pop_bank0");
    wr(1, 32'hC, 32'h1);
    tick();
    rd(1, 32'h0, 32'h0000_0101, "ac_after_release");
    rd(1, 32'h4, 32'd4, "ac_len_bank1");
    rd(1, 32'h8, 32'h50, "ac_pop_bank1");

    // Symbol and frame_done in the same cycle
    send(0, 8'h31);
    send(0, 8'h32);
    send(0, 8'h33, 1'b1);
    rd(0, 32'h4, 32'd3, "t4_len");
    for (int i = 0; i < 3; i++) rd(0, 32'h8, 32'h31 + 32'(i), "t4_pop");
    rd(0, 32'h8, 32'h0, "t4_pop_empty");
    wr(0, 32'hC, 32'h1);
    rd(0, 32'h0, 32'h0, "t4_released");

    // Undecoded offsets and read+write collisions have no effect
    send(0, 8'h61);
    send(0, 8'h62);
    close(0);
    rd_none(0, 32'h10, "rd_off_0x10");
    rd_none(0, 32'hFFFF_FFFC, "rd_off_neg4");
    wr(0, 32'hC, 32'h1, 1'b1);
    wr(0, 32'h1C, 32'h7);
    wr(0, 32'h0, 32'h1);
    rd(0, 32'h0, 32'h0000_0101, "t5_status");
    rd(0, 32'h4, 32'd2, "t5_len");
    rd(0, 32'h8, 32'h61, "t5_pop");
    probe(0, 34'h2_FFFF_FFFF, 34'h2_0000_0061, "pre_reset_outputs");
    tick();

    // Asynchronous reset mid-frame: outputs clear before the next clock edge
    for (int i = 0; i < 7; i++) send(0, 8'h70 + 8'(i));
    @(posedge clk);
    #2;
    rst = 1'b1;
    begin
      probe_t p;
      p.t = 0; p.cyc = cyc; p.mask = ALL; p.exp = 34'h0; p.name = "rst_async_outputs";
      pq.push_back(p);
    end
    tick();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rd(0, 32'h0, 32'h0, "post_rst_status");
    rd(0, 32'h4, 32'h0, "post_rst_len");
    rd(0, 32'h8, 32'h0, "post_rst_pop");
    probe(0, 34'h2_0000_0000, 34'h0, "post_rst_irq");
    repeat (3) tick();
    done = 1'b1;
  end

endmodule

// File: doc/uart_rx_frame_buffer.md
Name: uart_rx_frame_buffer

Overview:
Parametrised successor to the two-FIFO ping-pong UART receive buffer. It stores received UART bytes into NUM_BANKS internal frame banks, filled in round-robin order. Completed frames are exposed to the host over the register bus: status, frame length, a data-pop register and a control register. It adds N-way banking, frame-length reporting, overflow and drop accounting, optional auto-close on a full bank, and explicit frame release.

Parameters:
DATA_W, 8, received symbol width; must be 32 or less
DEPTH, 1024, symbols per bank; must be a power of two
NUM_BANKS, 2, number of frame banks; must be 2 or more
AUTO_CLOSE, 0, 1 = a bank that reaches DEPTH closes automatically as if frame_done were pulsed
CNT_W (localparam), clog2(DEPTH+1), width of the per-bank length counter

Ports:
clk  in  1  single clock for the whole block
rst  in  1  asynchronous reset, active-high
rx_vld  in  1  one-cycle strobe: rx_data is valid
rx_data  in  DATA_W  received symbol
frame_done  in  1  one-cycle strobe: close the current write bank
bus_addr_in  in  32  bus address
bus_data_in  in  32  bus write data
bus_read_en  in  1  bus read strobe
bus_write_en  in  1  bus write strobe
bus_base_addr  in  32  base address of this block's register window
bus_data_out  out  32  read data
bus_data_out_en  out  1  read data valid
irq  out  1  level: at least one frame is READY

Behaviour:
- Bank states: FREE, FILLING, READY. Storage is a NUM_BANKS*DEPTH x DATA_W array with synchronous read. Each bank has a length counter len[b] of width CNT_W.
- Reset (async): all banks FREE except bank 0, which is FILLING. wbank=0, rbank=0, rd_ptr=0, all len=0, overflow=0, drop_cnt=0, stall=0. bus_data_out=0, bus_data_out_en=0, irq=0.
- Write path, rx_vld=1:
  - If wbank is FILLING and len<DEPTH: store at {wbank,len}, then len+1.
  - Otherwise (bank full with AUTO_CLOSE=0, or stall=1): drop the symbol, set overflow=1, drop_cnt+1 saturating at 0xFFFF.
- Closing a bank (frame_done, or auto-close when len reaches DEPTH):
  - len=0: no action.
  - len>0: wbank becomes READY. If bank (wbank+1) mod NUM_BANKS is FREE in the current registered state, that bank becomes wbank in FILLING with len=0. Otherwise stall=1.
- While stall=1: the first cycle the next bank is observed FREE, it becomes FILLING and stall clears. Symbols arriving during stall are dropped.
- rx_vld and frame_done in the same cycle: the symbol is written first, then the bank closes with the incremented length.
- Register decode: off = bus_addr_in - bus_base_addr. Only 0x0, 0x4, 0x8 and 0xC respond. Any other offset gives no response and no side effect.
- Read response: bus_data_out_en pulses exactly 1 cycle after a decoded bus_read_en. bus_data_out holds its value until the next response.
- 0x0 STATUS (RO):
  - bit0: frame_avail (rbank is READY)
  - bit1: overflow
  - bit2: stall
  - [15:8]: number of READY banks
  - [31:16]: drop_cnt
- 0x4 FRAME_LEN (RO): len[rbank] if rbank is READY, else 0.
- 0x8 DATA (RO, pop): returns mem[{rbank,rd_ptr}] zero-extended to 32 bits, then rd_ptr+1. If rbank is not READY or rd_ptr=len, it returns 0 and does not advance.
- 0xC CTRL (WO, self-clearing bits), priority flush > release:
  - bit0 release: if rbank is READY, it becomes FREE, len=0, rd_ptr=0, rbank=(rbank+1) mod NUM_BANKS.
  - bit1 clear: overflow=0, drop_cnt=0.
  - bit2 flush: all banks and pointers return to their reset values; counters are unaffected.
- bus_read_en and bus_write_en asserted together: the write is ignored.
- irq is registered and equals frame_avail one cycle later.
- Release in the same cycle as a close that targets the released bank: the close sees the old state and stalls; the stall resolves on the next cycle.

Test Plan:
- Reset, send 5 symbols 0x11..0x15, then pulse frame_done -> STATUS=0x00000101, FRAME_LEN=5, irq=1; five DATA reads return 0x11..0x15, a sixth returns 0.
- NUM_BANKS=2: close two 3-symbol frames, send 4 more and close -> stall=1, drop_cnt=4, overflow=1; release -> next cycle stall=0, rbank=1.
- AUTO_CLOSE=0, DEPTH=16: send 20 symbols -> FRAME_LEN stays 16 after close, drop_cnt=4. AUTO_CLOSE=1: send 20 -> bank0 len=16, bank1 len=4 after frame_done.
- rx_vld and frame_done in the same cycle on the 3rd symbol -> FRAME_LEN=3.
- Read at off=0x10, and write CTRL with bus_read_en also high -> no bus_data_out_en, no state change. Write CTRL=0x2 -> STATUS[31:16]=0, bit1=0.
- Assert rst mid-frame after 7 symbols -> all outputs 0 immediately; after release, STATUS=0 and FRAME_LEN=0.
